// File: rtl/fpm_pkg.sv
// rtl/fpm_pkg.sv - shared types and constants for the floating-point product sequencer
package fpm_pkg;

  localparam int DW_DEFAULT = 32;

  // Quiet NaN written in place of a product the multiplier never delivered.
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;

  localparam logic RAM_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    LAUNCH = 3'd3,
    WAIT   = 3'd4,
    STORE  = 3'd5,
    DONE   = 3'd6
  } fpm_state_e;

endpackage

// File: rtl/fpm_watchdog.sv
// rtl/fpm_watchdog.sv - WAIT-cycle counter that flags a multiplier that never finishes
module fpm_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear when a product is launched, count every WAIT cycle that did not finish.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count seen in WAIT cycle k is k-1, so this fires on the LIMIT-th WAIT cycle.
  assign expired_o = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/fpm_sequencer.sv
// rtl/fpm_sequencer.sv - ROM -> fp_mult -> RAM batch controller (optional watchdog: FPM_TIMEOUT_EN)
module fpm_sequencer
  import fpm_pkg::*;
#(
  parameter int N_PAIRS        = 4,
  parameter int ROM_AW         = 3,
  parameter int RAM_AW         = 2,
  parameter int DW             = DW_DEFAULT,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_oe,
  input  logic [DW-1:0]     rom_data,
  output logic [DW-1:0]     mul_a,
  output logic [DW-1:0]     mul_b,
  output logic              mul_en,
  output logic              mul_rst,
  input  logic              mul_done,
  input  logic [DW-1:0]     mul_z,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_wdata,
  output logic              ram_rw,
  output logic              ram_oe,
  input  logic [RAM_AW-1:0] rd_addr,
  output logic              err
);

  localparam logic [RAM_AW-1:0] LAST_IDX = RAM_AW'(N_PAIRS - 1);

  fpm_state_e        state_q, state_d;
  logic [RAM_AW-1:0] idx_q, idx_d;
  logic [DW-1:0]     mul_a_q, mul_a_d;
  logic [DW-1:0]     mul_b_q, mul_b_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              wd_clr, wd_inc, timeout;

  // State, pair index and datapath registers; reset aborts any batch at once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; the last-pair check comes before the increment so idx never wraps.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    wd_clr  = 1'b0;
    wd_inc  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD_A;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD_A: begin
        mul_a_d = rom_data;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        mul_b_d = rom_data;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        // mul_done is deliberately ignored here: it may still be high from the last product.
        wd_clr  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          wdata_d = mul_z;
          state_d = STORE;
        end else if (timeout) begin
`ifdef FPM_TIMEOUT_EN
          wdata_d = FP_QNAN;
          err_d   = 1'b1;
          state_d = STORE;
`endif
        end else begin
          wd_inc = 1'b1;
        end
      end
      STORE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = LOAD_A;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ROM address: even word for operand A, odd word for operand B.
  always_comb begin
    rom_addr = '0;
    if (state_q == LOAD_A) begin
      rom_addr = ROM_AW'({idx_q, 1'b0});
    end else if (state_q == LOAD_B) begin
      rom_addr = ROM_AW'({idx_q, 1'b1});
    end
  end

  assign busy      = (state_q inside {LOAD_A, LOAD_B, LAUNCH, WAIT, STORE});
  assign done      = (state_q == DONE);
  assign rom_oe    = busy;
  assign mul_en    = (state_q inside {LAUNCH, WAIT});
  assign mul_rst   = ~mul_en;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign ram_wdata = wdata_q;
  assign ram_rw    = (state_q == STORE) ? RAM_WRITE : ~RAM_WRITE;
  assign ram_oe    = 1'b1;
  assign ram_addr  = busy ? idx_q : rd_addr;
  assign err       = err_q;

`ifdef FPM_TIMEOUT_EN
  fpm_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .inc_i    (wd_inc),
    .expired_o(timeout)
  );
`else
  // Without the watchdog WAIT blocks until the multiplier answers and err stays 0.
  logic unused_wd;
  assign timeout   = 1'b0;
  assign unused_wd = wd_clr ^ wd_inc ^ (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_fpm_sequencer.sv
// tb/tb_fpm_sequencer.sv - randomized self-checking bench for fpm_sequencer
module tb_fpm_sequencer;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, rom_oe, mul_en, mul_rst, ram_rw, ram_oe, err;
  logic [2:0]  rom_addr;
  logic [1:0]  ram_addr, rd_addr;
  logic [31:0] rom_data, mul_a, mul_b, ram_wdata;
  logic        mul_done = 1'b0;
  logic [31:0] mul_z = '0;

  logic [31:0] rom [0:7];
  logic [31:0] ram [0:3];
  logic [31:0] spec_rom [0:7];
  logic [31:0] spec_ram [0:3];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int          wa[$];
  logic [31:0] wd[$];
  int          wc[$];

  int lat_tab [0:3];
  int hang_pair = -1;
  bit stale_mode = 1'b0;
  int st_cnt = 0;

  always #5 clk = ~clk;

  fpm_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_oe(rom_oe), .rom_data(rom_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_rst(mul_rst),
    .mul_done(mul_done), .mul_z(mul_z), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rw(ram_rw), .ram_oe(ram_oe),
    .rd_addr(rd_addr), .err(err)
  );

  assign rom_data = rom[rom_addr];

  // Stand-in product: exact IEEE results for the reference vectors, an asymmetric mix otherwise.
  function automatic logic [31:0] fref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40000000_40400000: return 32'h40C00000;
      64'h3FC00000_C0000000: return 32'hC0400000;
      64'h3F800000_3F800000: return 32'h3F800000;
      64'h00000000_42F60000: return 32'h00000000;
      default:               return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0001;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (ram_rw) ram[ram_addr] <= ram_wdata;

  always @(negedge clk) begin
    if (ram_rw === 1'b1) begin
      wa.push_back(int'(ram_addr));
      wd.push_back(ram_wdata);
      wc.push_back(cyc);
    end
  end

  // Multiplier stub: pair p finishes after lat_tab[p] enabled cycles; hang_pair never finishes.
  always @(posedge clk) begin
    if (mul_rst) begin
      st_cnt   <= 0;
      mul_done <= stale_mode;
      mul_z    <= $urandom;
    end else if (mul_en) begin
      st_cnt   <= st_cnt + 1;
      mul_done <= (st_cnt + 1 >= lat_tab[wa.size() % 4]) && (wa.size() != hang_pair);
      mul_z    <= fref(mul_a, mul_b);
    end
  end

  task automatic run_batch(input bit use_spec, input bit hold, input int hang);
    int c0, t, total, w;
    int off [0:3];
    logic [31:0] exp_d [0:3];
    bit exp_err;
    for (int p = 0; p < 4; p++) begin
      rom[2*p]     = use_spec ? spec_rom[2*p]     : $urandom;
      rom[2*p + 1] = use_spec ? spec_rom[2*p + 1] : $urandom;
      lat_tab[p]   = $urandom_range(1, 6);
    end
    hang_pair = hang;
    total = 0;
    for (int p = 0; p < 4; p++) begin
      w        = (p == hang) ? 255 : lat_tab[p];
      off[p]   = total + 3 + w;
      total   += 4 + w;
      exp_d[p] = (p == hang) ? QNAN : fref(rom[2*p], rom[2*p + 1]);
    end
`ifdef FPM_TIMEOUT_EN
    exp_err = (hang >= 0);
`else
    exp_err = 1'b0;
`endif
    @(negedge clk);
    wa.delete(); wd.delete(); wc.delete();
    start = 1'b1;
    @(negedge clk);
    c0 = cyc;
    if (!hold) start = 1'b0;
    check_eq("busy_first_load", busy, 1);
    check_eq("done_drops", done, 0);
    check_eq("err_clear_on_start", err, 0);
    t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
      if (!hold && t == 5) start = 1'b1;
      if (!hold && t == 6) start = 1'b0;
    end
    check_eq("batch_completes", t < 3000, 1);
    check_eq("write_count", wa.size(), 4);
    for (int p = 0; p < 4 && p < wa.size(); p++) begin
      check_eq($sformatf("write_addr%0d", p), wa[p], p);
      check_eq($sformatf("write_data%0d", p), wd[p], exp_d[p]);
      check_eq($sformatf("write_cycle%0d", p), wc[p] - c0, off[p]);
      check_eq($sformatf("ram%0d", p), ram[p], exp_d[p]);
    end
    check_eq("done_latency", cyc - c0, total);
    check_eq("busy_in_done", busy, 0);
    check_eq("err_at_done", err, exp_err);
    if (hold) begin
      @(negedge clk);
      check_eq("held_start_restarts", busy, 1);
      check_eq("held_start_done_low", done, 0);
      start = 1'b0;
      t = 0;
      while (!done && t < 3000) begin
        @(negedge clk);
        t++;
      end
      check_eq("second_batch_completes", t < 3000, 1);
    end
  endtask

  initial begin
    spec_rom = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'hC0000000,
                 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h42F60000};
    spec_ram = '{32'h40C00000, 32'hC0400000, 32'h3F800000, 32'h00000000};
    for (int i = 0; i < 8; i++) rom[i] = spec_rom[i];
    for (int i = 0; i < 4; i++) begin
      ram[i]     = 32'hDEADBEEF;
      lat_tab[i] = 1;
    end
    rst = 1'b0; start = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_mul_rst", mul_rst, 1);
    check_eq("rst_mul_en", mul_en, 0);
    check_eq("rst_ram_rw", ram_rw, 0);
    check_eq("rst_rom_oe", rom_oe, 0);
    check_eq("rst_rom_addr", rom_addr, 0);
    check_eq("rst_mul_a", mul_a, 0);
    check_eq("rst_mul_b", mul_b, 0);
    check_eq("rst_wdata", ram_wdata, 0);
    check_eq("rst_err", err, 0);
    check_eq("ram_oe", ram_oe, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_batch(1'b1, 1'b0, -1);

    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      rd_addr = 2'(a);
      #1;
      check_eq("sweep_addr", ram_addr, a);
      check_eq("sweep_rw", ram_rw, 0);
      check_eq("sweep_data", ram[ram_addr], spec_ram[a]);
    end

    for (int i = 0; i < 4; i++) ram[i] = 32'hDEADBEEF;
    lat_tab = '{2, 30, 2, 2};
    hang_pair = -1;
    @(negedge clk);
    wa.delete(); wd.delete(); wc.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 200 && (wa.size() < 1 || !mul_en); t++) @(negedge clk);
    @(negedge clk);
    check_eq("in_wait_pair1", mul_en, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_mul_rst", mul_rst, 1);
    check_eq("abort_ram_rw", ram_rw, 0);
    repeat (40) @(negedge clk);
    check_eq("abort_writes", wa.size(), 1);
    check_eq("abort_ram0", ram[0], 32'h40C00000);
    check_eq("abort_ram1", ram[1], 32'hDEADBEEF);
    check_eq("abort_stays_idle", busy | done, 0);

    run_batch(1'b1, 1'b0, -1);
    run_batch(1'b1, 1'b1, -1);

    stale_mode = 1'b1;
    run_batch(1'b0, 1'b0, -1);
    stale_mode = 1'b0;

    for (int r = 0; r < 3; r++) run_batch(1'b0, 1'b0, -1);

`ifdef FPM_TIMEOUT_EN
    run_batch(1'b1, 1'b0, 2);
    run_batch(1'b0, 1'b0, -1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpm_sequencer.md
Name: fpm_sequencer

Overview:
- Synthesizable clocked controller that runs the floating-point product batch: reads operand pairs from rom_8, drives fp_mult, and writes each product into ram_4.
- Replaces procedural delay-based sequencing with an FSM on the system clock.
- Owns the RAM address mux. The external reader (juiz port) gets the RAM address only while the sequencer is not writing.

Parameters:
- N_PAIRS, 4, number of operand pairs/products; ROM holds 2*N_PAIRS words.
- ROM_AW, 3, ROM address width.
- RAM_AW, 2, RAM address width.
- DW, 32, IEEE-754 single-precision word width.
- TIMEOUT_CYCLES, 255, watchdog limit in WAIT (used only with FPM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; also drives fp_mult clk.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to run the batch.
- busy  out  1  high from the first LOAD_A through the last STORE.
- done  out  1  high in DONE; held until next start or reset.
- rom_addr  out  ROM_AW  ROM word address.
- rom_oe  out  1  ROM output enable; high while busy.
- rom_data  in  DW  combinational ROM data.
- mul_a  out  DW  multiplier operand A (registered).
- mul_b  out  DW  multiplier operand B (registered).
- mul_en  out  1  multiplier enable.
- mul_rst  out  1  multiplier reset, active-high.
- mul_done  in  1  multiplier completion.
- mul_z  in  DW  multiplier result.
- ram_addr  out  RAM_AW  muxed RAM address.
- ram_wdata  out  DW  RAM write data (registered).
- ram_rw  out  1  1 = write, 0 = read.
- ram_oe  out  1  RAM output enable; constant 1.
- rd_addr  in  RAM_AW  external read address.
- err  out  1  timeout flag (FPM_TIMEOUT_EN only, else tied 0).

Behaviour:
- Reset (rst=0 at a clk edge), effective next cycle:
  - State, counters and registers: state=IDLE, idx=0, mul_a=mul_b=ram_wdata=0.
  - Outputs: mul_en=0, mul_rst=1, ram_rw=0, busy=0, done=0, err=0, rom_addr=0, rom_oe=0.
  - Reset mid-batch aborts immediately. RAM contents already written remain; no further writes.
- IDLE: mul_rst=1. On start, go to LOAD_A with idx=0.
- LOAD_A:
  - rom_addr=2*idx; mul_a<=rom_data at cycle end; mul_rst=1.
  - Go to LOAD_B.
- LOAD_B:
  - rom_addr=2*idx+1; mul_b<=rom_data.
  - Go to LAUNCH.
- LAUNCH:
  - mul_rst=0, mul_en=1.
  - Go to WAIT.
  - mul_done is not sampled in this cycle, so a stale done is ignored.
- WAIT:
  - mul_rst=0, mul_en=1.
  - On mul_done=1: ram_wdata<=mul_z, go to STORE.
- STORE:
  - ram_rw=1 for exactly one cycle; ram_addr=idx; mul_en=0; mul_rst=1.
  - If idx==N_PAIRS-1, go to DONE. Otherwise idx<=idx+1 and go to LOAD_A.
- DONE:
  - done=1, busy=0, ram_rw=0.
  - start restarts the batch from idx=0 (done drops the next cycle).
- Address mux: ram_addr = idx while state in {LOAD_A..STORE}, else rd_addr.
- start while busy is ignored.
- Latency:
  - Per pair: 4 + W cycles, where W (≥1) is the number of WAIT cycles.
  - done rises the cycle after the final STORE.
- idx width = RAM_AW; it never wraps, because the DONE check precedes the increment.
- No arithmetic in this block; the product comes from fp_mult unchanged.

Optional Feature:
- Macro: FPM_TIMEOUT_EN.
- Enabled:
  - A wait counter clears in LAUNCH and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without mul_done, ram_wdata<=32'h7FC00000 (qNaN), err is set sticky, and the FSM goes to STORE.
  - The batch continues to the next pair.
  - err clears only on reset or start.
- Disabled: no counter; WAIT blocks indefinitely; err tied 0.

Decomposition:
- Shared package fpm_pkg holds:
  - state enum (IDLE, LOAD_A, LOAD_B, LAUNCH, WAIT, STORE, DONE);
  - DW default;
  - FP_QNAN = 32'h7FC00000;
  - RAM_WRITE = 1'b1.
- Sub-module fpm_watchdog (counter plus compare, instantiated only under FPM_TIMEOUT_EN) is natural; the rest stays flat.

Test Plan:
- ROM = {40000000, 40400000, 3FC00000, C0000000, 3F800000, 3F800000, 00000000, 42F60000}; pulse start.
  - Required: RAM = {40C00000, C0400000, 3F800000, 00000000}, one ram_rw pulse per index 0..3 in order, then done=1 and busy=0.
- After done: sweep rd_addr 0..3.
  - Required: ram_addr follows rd_addr, ram_rw=0, reads match the values above.
- Assert rst=0 while in WAIT of pair 1.
  - Required: next cycle state IDLE, mul_rst=1, busy=0, done=0; RAM[0]=40C00000, RAM[1] not written.
  - Re-start then completes the full batch.
- Hold start high for the whole run, and pulse start mid-batch.
  - Required: no restart and exactly 4 writes; with start still high in DONE, a new batch begins.
- Stub multiplier with mul_done already high at LAUNCH.
  - Required: WAIT still entered, with no write in the LAUNCH cycle.
- FPM_TIMEOUT_EN with mul_done never asserted for pair 2.
  - Required: after 255 WAIT cycles, RAM[2]=7FC00000 and err=1; pair 3 is still computed; done=1.
